// File: rtl/counter_down_sync_load.sv
// Synchronous loadable down counter / interval timer with start/done handshake.
// Optional feature macro: COUNTER_DOWN_SYNC_LOAD_AUTORELOAD_EN (periodic reload on reaching 0).
module counter_down_sync_load #(
  parameter int WIDTH = 4
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadVal,
  input  logic             Start,
  input  logic             En,
  output logic [WIDTH-1:0] count,
  output logic             Busy,
  output logic             Done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             busy_q;
  logic             done_q, done_d;

  // Next-state decode in priority order Load > Start > En; Clr is applied in the register block.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    done_d   = 1'b0;

    if (Load) begin
      count_d  = LoadVal;
      reload_d = LoadVal;
      state_d  = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (Start) begin
            if (count_q != '0) begin
              state_d = RUN;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        RUN: begin
          if (En) begin
            if (count_q > ONE) begin
              count_d = count_q - ONE;
            end else if (count_q == ONE) begin
              count_d = '0;
              done_d  = 1'b1;
`ifdef COUNTER_DOWN_SYNC_LOAD_AUTORELOAD_EN
              state_d = RUN;
`else
              state_d = IDLE;
`endif
            end else begin
`ifdef COUNTER_DOWN_SYNC_LOAD_AUTORELOAD_EN
              // Reload period; a zero reload value keeps pulsing Done every enabled cycle.
              count_d = reload_q;
              if (reload_q == '0) begin
                done_d = 1'b1;
              end
`else
              state_d = IDLE;
`endif
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Clr) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      busy_q   <= (state_d == RUN);
      done_q   <= done_d;
    end
  end

  assign count = count_q;
  assign Busy  = busy_q;
  assign Done  = done_q;

endmodule
